// File: rtl/inst_fetch_multi_if.sv
// Fetch-stage bundle: icache request/response, redirects and the decode-side queue head.
// master = fetch unit, slave = icache/decode/redirect environment.
interface inst_fetch_multi_if #(
    parameter int N_ISSUE  = 2,
    parameter int FQ_DEPTH = 4
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic                   icache_req;
    logic [31:0]            icache_vaddr;
    logic                   icache_ready;
    logic                   icache_valid;
    logic [32*N_ISSUE-1:0]  icache_data;
    logic                   except_valid;
    logic [31:0]            except_target;
    logic                   branch_valid;
    logic [31:0]            branch_target;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [31:0]            deq_pc;
    logic [32*N_ISSUE-1:0]  deq_inst;
    logic [N_ISSUE-1:0]     deq_mask;
    logic [CW-1:0]          fq_count;

    modport master (
        output icache_req, icache_vaddr, deq_valid, deq_pc, deq_inst, deq_mask, fq_count,
        input  icache_ready, icache_valid, icache_data,
               except_valid, except_target, branch_valid, branch_target, deq_ready
    );

    modport slave (
        input  icache_req, icache_vaddr, deq_valid, deq_pc, deq_inst, deq_mask, fq_count,
        output icache_ready, icache_valid, icache_data,
               except_valid, except_target, branch_valid, branch_target, deq_ready
    );
endinterface

// File: rtl/inst_fetch_multi.sv
// Multi-issue fetch: owns the fetch PC, keeps one packet request in flight to the icache
// and buffers returned packets in a circular fetch queue feeding decode.
module inst_fetch_multi #(
    parameter logic [31:0] BOOT_VEC = 32'hbfc00000,
    parameter int          N_ISSUE  = 2,
    parameter int          FQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_multi_if.master   bus
);
    localparam int              A         = $clog2(4 * N_ISSUE);
    localparam int              PW        = $clog2(FQ_DEPTH);
    localparam int              CW        = PW + 1;
    localparam int              SW        = (N_ISSUE > 1) ? $clog2(N_ISSUE) : 1;
    localparam int              DW        = 32 * N_ISSUE;
    localparam logic [31:0]     PKT_BYTES = 32'(4 * N_ISSUE);
    localparam logic [CW-1:0]   FULL      = CW'(FQ_DEPTH);

    logic [31:0]        pc;
    logic [31:0]        req_pc;
    logic [31:0]        pc_aligned;
    logic               outstanding;
    logic               drop;
    logic               started;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic [31:0]        mem_pc   [FQ_DEPTH];
    logic [DW-1:0]      mem_inst [FQ_DEPTH];
    logic [N_ISSUE-1:0] mem_mask [FQ_DEPTH];

    logic               redirect;
    logic [31:0]        redirect_target;
    logic               req;
    logic               fire;
    logic               resp;
    logic               push;
    logic               pop;
    logic               not_empty;
    logic [SW-1:0]      slot_off;
    logic [N_ISSUE-1:0] resp_mask;

    assign redirect        = bus.except_valid | bus.branch_valid;
    assign redirect_target = bus.except_valid ? bus.except_target : bus.branch_target;
    assign pc_aligned      = {pc[31:A], {A{1'b0}}};
    assign not_empty       = (count != '0);

    // started holds off the request for the first cycle after reset, so that cycle
    // always shows an idle request port.
    assign req  = started && !outstanding && (count < FULL) && !redirect;
    assign fire = req && bus.icache_ready;
    assign resp = bus.icache_valid && outstanding;
    assign push = resp && !drop && !redirect;
    assign pop  = not_empty && bus.deq_ready && !redirect;

    generate
        if (N_ISSUE == 1) begin : g_single
            assign slot_off = '0;
        end else begin : g_multi
            assign slot_off = req_pc[A-1:2];
        end
    endgenerate

    // Slots before the entry point of the packet are invalid.
    always_comb begin
        resp_mask = '0;
        for (int unsigned i = 0; i < N_ISSUE; i++) begin
            resp_mask[i] = (SW'(i) >= slot_off);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= BOOT_VEC;
            req_pc      <= BOOT_VEC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            started     <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            started <= 1'b1;

            if (fire) begin
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end

            if (redirect) begin
                pc    <= redirect_target;
                drop  <= outstanding && !bus.icache_valid;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (fire) begin
                    pc     <= pc_aligned + PKT_BYTES;
                    req_pc <= pc;
                end
                if (resp) begin
                    drop <= 1'b0;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_pc[tail]   <= req_pc;
            mem_inst[tail] <= bus.icache_data;
            mem_mask[tail] <= resp_mask;
        end
    end

    assign bus.icache_req   = req;
    assign bus.icache_vaddr = pc_aligned;
    assign bus.deq_valid    = not_empty;
    assign bus.deq_pc       = mem_pc[head];
    assign bus.deq_inst     = mem_inst[head];
    assign bus.deq_mask     = not_empty ? mem_mask[head] : '0;
    assign bus.fq_count     = count;
endmodule

// File: tb/tb_inst_fetch_multi.sv
// Directed bench for inst_fetch_multi (N_ISSUE=2, FQ_DEPTH=4) with a cycle-level
// reference model and a scoreboard of expected queue entries.
module tb_inst_fetch_multi;
    localparam logic [31:0] BOOT = 32'hbfc00000;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;

    inst_fetch_multi_if #(.N_ISSUE(2), .FQ_DEPTH(4)) bus ();

    inst_fetch_multi #(.BOOT_VEC(BOOT), .N_ISSUE(2), .FQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;
    pkt_t        sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] m_pc     = BOOT;
    logic [31:0] m_req_pc = BOOT;
    logic        pend     = 1'b0;
    logic        drop     = 1'b0;
    logic        started  = 1'b0;
    logic        auto_resp   = 1'b1;
    logic        stray_valid = 1'b0;

    function automatic logic [31:0] align8(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

    function automatic logic [63:0] pkt_data(input logic [31:0] a);
        logic [31:0] b;
        b = align8(a);
        return {(b + 32'd4) ^ 32'h2468ace0, b ^ 32'h13579bdf};
    endfunction

    function automatic logic [1:0] exp_mask(input logic [31:0] a);
        return a[2] ? 2'b10 : 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        fails++;
        $error("FAIL %s: observed no event expected one within cycle bound", tag);
    endtask

    // One clock cycle: drive icache response, check outputs against the model,
    // advance the model to the next edge, return at the following negedge.
    task automatic step();
        logic        redir;
        logic        exp_req;
        logic        fire;
        logic        resp;
        logic        pop;
        logic [31:0] tgt;
        bus.icache_valid = stray_valid || (auto_resp && pend);
        bus.icache_data  = pkt_data(m_req_pc);
        #1;
        redir   = bus.except_valid || bus.branch_valid;
        tgt     = bus.except_valid ? bus.except_target : bus.branch_target;
        exp_req = started && !pend && (sb.size() < 4) && !redir;
        fire    = rst && exp_req && bus.icache_ready;
        resp    = rst && bus.icache_valid && pend;
        pop     = rst && (sb.size() != 0) && bus.deq_ready && !redir;
        if (rst) begin
            chk("icache_req", 64'(bus.icache_req), 64'(exp_req));
            chk("fq_count", 64'(bus.fq_count), 64'(sb.size()));
            chk("deq_valid", 64'(bus.deq_valid), 64'(sb.size() != 0));
            if (exp_req) chk("icache_vaddr", 64'(bus.icache_vaddr), 64'(align8(m_pc)));
            if (fire) acc_log.push_back(bus.icache_vaddr);
            if (sb.size() != 0) begin
                chk("deq_pc", 64'(bus.deq_pc), 64'(sb[0].pc));
                chk("deq_inst", bus.deq_inst, sb[0].inst);
                chk("deq_mask", 64'(bus.deq_mask), 64'(sb[0].mask));
            end
        end
        if (!rst) begin
            sb.delete();
            pend    = 1'b0;
            drop    = 1'b0;
            started = 1'b0;
            m_pc    = BOOT;
        end else begin
            started = 1'b1;
            if (redir) begin
                drop = pend && !resp;
                if (resp) pend = 1'b0;
                sb.delete();
                m_pc = tgt;
            end else begin
                if (pop) void'(sb.pop_front());
                if (resp) begin
                    pend = 1'b0;
                    if (!drop) sb.push_back('{pc: m_req_pc, inst: pkt_data(m_req_pc), mask: exp_mask(m_req_pc)});
                    drop = 1'b0;
                end
                if (fire) begin
                    pend     = 1'b1;
                    m_req_pc = m_pc;
                    m_pc     = align8(m_pc) + 32'd8;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic next_fire(input string tag, input logic [31:0] want);
        int mark;
        mark = acc_log.size();
        for (int i = 0; i < 40 && acc_log.size() == mark; i++) step();
        if (acc_log.size() == mark) timeout(tag);
        else chk(tag, 64'(acc_log[mark]), 64'(want));
    endtask

    initial begin
        rst               = 1'b0;
        bus.icache_ready  = 1'b1;
        bus.icache_valid  = 1'b0;
        bus.icache_data   = '0;
        bus.except_valid  = 1'b0;
        bus.except_target = '0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        bus.deq_ready     = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_icache_req", 64'(bus.icache_req), 64'd0);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("rst_fq_count", 64'(bus.fq_count), 64'd0);
        chk("rst_deq_mask", 64'(bus.deq_mask), 64'd0);
        step();
        rst = 1'b1;

        // sequential fetch from boot vector
        for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
        if (acc_log.size() < 3) timeout("boot_seq");
        else begin
            chk("vaddr0", 64'(acc_log[0]), 64'hbfc00000);
            chk("vaddr1", 64'(acc_log[1]), 64'hbfc00008);
            chk("vaddr2", 64'(acc_log[2]), 64'hbfc00010);
        end
        bus.icache_ready = 1'b0;
        repeat (3) step();
        bus.icache_ready = 1'b1;
        repeat (3) step();

        // fill the queue with decode stalled
        bus.deq_ready = 1'b0;
        repeat (14) step();
        chk("full_count", 64'(bus.fq_count), 64'd4);
        chk("full_no_req", 64'(bus.icache_req), 64'd0);
        bus.deq_ready = 1'b1;
        step();
        bus.deq_ready = 1'b0;
        chk("slot_free_req", 64'(bus.icache_req), 64'd1);
        chk("slot_free_count", 64'(bus.fq_count), 64'd3);
        repeat (3) step();

        // branch while a request is outstanding
        auto_resp     = 1'b0;
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 20 && !pend; i++) step();
        if (!pend) timeout("branch_setup");
        bus.deq_ready     = 1'b0;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h80000004;
        step();
        bus.branch_valid = 1'b0;
        auto_resp        = 1'b1;
        step();
        chk("stale_drop", 64'(bus.fq_count), 64'd0);
        next_fire("branch_vaddr", 32'h80000000);
        for (int i = 0; i < 20 && sb.size() == 0; i++) step();
        if (sb.size() == 0) timeout("branch_enq");
        else begin
            chk("branch_deq_pc", 64'(bus.deq_pc), 64'h80000004);
            chk("branch_deq_mask", 64'(bus.deq_mask), 64'h2);
        end
        next_fire("branch_vaddr_next", 32'h80000008);

        // exception wins over a same-cycle branch
        bus.deq_ready     = 1'b1;
        bus.except_valid  = 1'b1;
        bus.except_target = 32'hbfc00380;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h80001000;
        step();
        bus.except_valid = 1'b0;
        bus.branch_valid = 1'b0;
        next_fire("except_prio", 32'hbfc00380);

        // response in the same cycle as a branch
        auto_resp = 1'b0;
        for (int i = 0; i < 20 && !pend; i++) step();
        if (!pend) timeout("same_cycle_setup");
        auto_resp         = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h00001000;
        step();
        bus.branch_valid = 1'b0;
        chk("same_cycle_count", 64'(bus.fq_count), 64'd0);
        next_fire("same_cycle_vaddr", 32'h00001000);

        // address wrap at the top of the space
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'hfffffffc;
        step();
        bus.branch_valid = 1'b0;
        next_fire("wrap_vaddr0", 32'hfffffff8);
        next_fire("wrap_vaddr1", 32'h00000000);

        // reset with a request in flight and three entries queued
        bus.deq_ready     = 1'b0;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h00002000;
        step();
        bus.branch_valid = 1'b0;
        for (int i = 0; i < 40 && !(sb.size() == 3 && pend); i++) step();
        if (!(sb.size() == 3 && pend)) timeout("rst_setup");
        auto_resp   = 1'b0;
        stray_valid = 1'b1;
        rst         = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_mid_count", 64'(bus.fq_count), 64'd0);
        chk("rst_mid_req", 64'(bus.icache_req), 64'd0);
        step();
        stray_valid = 1'b0;
        chk("rst_after_req", 64'(bus.icache_req), 64'd1);
        chk("rst_after_vaddr", 64'(bus.icache_vaddr), 64'hbfc00000);
        chk("rst_after_count", 64'(bus.fq_count), 64'd0);
        auto_resp     = 1'b1;
        bus.deq_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
